// File: rtl/refresh_restore_handler.sv
// Refresh-with-restore sequencer: snapshots the open-row tracker, closes the open banks,
// issues one REF, then re-opens the same rows so the application view is unchanged.
module refresh_restore_handler #(
    parameter int ROW_WIDTH  = 15,
    parameter int BANK_WIDTH = 3,
    parameter int CS_WIDTH   = 1,
    parameter int TRP        = 6,
    parameter int TRFC       = 44,
    parameter int TRRD       = 4,
    parameter int TRCD       = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  maint_req,
    output logic                  maint_busy,
    output logic                  maint_done,
    output logic [BANK_WIDTH-1:0] maint_bank,
    input  logic [ROW_WIDTH:0]    maint_bank_state,
    output logic [31:0]           instr,
    output logic                  is_mnt,
    input  logic                  instr_ready
);
    localparam int NUM_BANKS = 1 << BANK_WIDTH;
    localparam int CS_OFFSET = ROW_WIDTH + BANK_WIDTH;
    localparam int RAS_BIT   = 30;
    localparam int CAS_BIT   = 29;
    localparam int WE_BIT    = 28;
    localparam logic [7:0] TRP_M1  = 8'(TRP - 1);
    localparam logic [7:0] TRFC_M1 = 8'(TRFC - 1);
    localparam logic [7:0] TRRD_M1 = 8'(TRRD - 1);
    localparam logic [7:0] TRCD_M1 = 8'(TRCD - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC,
        S_ACT, S_WAIT_RRD, S_WAIT_RCD, S_DONE
    } state_t;
    typedef enum logic [2:0] {L_NONE, L_PRE, L_REF, L_ACT, L_DONE} launch_t;

    function automatic logic [31:0] encode(input logic ras, input logic cas, input logic we,
                                           input logic [BANK_WIDTH-1:0] bank,
                                           input logic [ROW_WIDTH-1:0] row);
        logic [31:0] w;
        w = '0;
        w[31] = 1'b1;
        w[RAS_BIT] = ras;
        w[CAS_BIT] = cas;
        w[WE_BIT]  = we;
        w[CS_OFFSET +: CS_WIDTH] = '0;
        w[ROW_WIDTH +: BANK_WIDTH] = bank;
        w[ROW_WIDTH-1:0] = row;
        return w;
    endfunction

    state_t                 state_reg, state_next;
    logic [7:0]             cnt_reg, cnt_next;
    logic [NUM_BANKS-1:0]   open_reg, open_next;
    logic [NUM_BANKS-1:0]   pend_reg, pend_next;
    logic [ROW_WIDTH-1:0]   row_reg [NUM_BANKS];
    logic [31:0]            instr_reg, instr_next;
    logic                   is_mnt_reg, is_mnt_next;
    logic                   done_reg, done_next;
    logic                   busy_reg, busy_next;
    logic [BANK_WIDTH-1:0]  bank_reg, bank_next;

    launch_t                launch;
    logic [NUM_BANKS-1:0]   pend_src;
    logic [NUM_BANKS-1:0]   one_hot;
    logic [BANK_WIDTH-1:0]  low_idx;
    logic                   accepted;
    logic                   rfc_end;

    assign accepted = is_mnt_reg && instr_ready;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        open_next   = open_reg;
        pend_next   = pend_reg;
        instr_next  = instr_reg;
        is_mnt_next = is_mnt_reg;
        done_next   = 1'b0;
        busy_next   = busy_reg;
        bank_next   = bank_reg;
        launch      = L_NONE;
        pend_src    = pend_reg;
        rfc_end     = 1'b0;

        case (state_reg)
            S_IDLE: if (maint_req) begin
                state_next = S_SCAN;
                bank_next  = '0;
                busy_next  = 1'b1;
                open_next  = '0;
            end
            S_SCAN: begin
                open_next[bank_reg] = maint_bank_state[ROW_WIDTH];
                if (bank_reg == BANK_WIDTH'(NUM_BANKS - 1)) begin
                    pend_src = open_next;
                    launch   = (open_next == '0) ? L_REF : L_PRE;
                end else begin
                    bank_next = bank_reg + 1'b1;
                end
            end
            S_PRE: if (accepted) begin
                is_mnt_next = 1'b0;
                instr_next  = '0;
                if (pend_reg != '0) launch = L_PRE;
                else if (TRP == 1) launch = L_REF;
                else begin
                    state_next = S_WAIT_RP;
                    cnt_next   = TRP_M1;
                end
            end
            S_WAIT_RP: if (cnt_reg <= 8'd1) launch = L_REF; else cnt_next = cnt_reg - 1'b1;
            S_REF: if (accepted) begin
                is_mnt_next = 1'b0;
                instr_next  = '0;
                if (TRFC == 1) rfc_end = 1'b1;
                else begin
                    state_next = S_WAIT_RFC;
                    cnt_next   = TRFC_M1;
                end
            end
            S_WAIT_RFC: if (cnt_reg <= 8'd1) rfc_end = 1'b1; else cnt_next = cnt_reg - 1'b1;
            S_ACT: if (accepted) begin
                is_mnt_next = 1'b0;
                instr_next  = '0;
                if (pend_reg == '0) begin
                    if (TRCD == 1) launch = L_DONE;
                    else begin
                        state_next = S_WAIT_RCD;
                        cnt_next   = TRCD_M1;
                    end
                end else if (TRRD == 1) launch = L_ACT;
                else begin
                    state_next = S_WAIT_RRD;
                    cnt_next   = TRRD_M1;
                end
            end
            S_WAIT_RRD: if (cnt_reg <= 8'd1) launch = L_ACT; else cnt_next = cnt_reg - 1'b1;
            S_WAIT_RCD: if (cnt_reg <= 8'd1) launch = L_DONE; else cnt_next = cnt_reg - 1'b1;
            S_DONE: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Row restore only needs the banks that were open when the snapshot was taken
        if (rfc_end) begin
            pend_src = open_reg;
            launch   = (open_reg != '0) ? L_ACT : L_DONE;
        end

        low_idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (pend_src[i]) low_idx = i[BANK_WIDTH-1:0];
        end
        one_hot = '0;
        one_hot[low_idx] = 1'b1;

        case (launch)
            L_PRE: begin
                instr_next  = encode(1'b0, 1'b1, 1'b0, low_idx, '0);
                is_mnt_next = 1'b1;
                pend_next   = pend_src & ~one_hot;
                state_next  = S_PRE;
            end
            L_REF: begin
                instr_next  = encode(1'b0, 1'b0, 1'b1, '0, '0);
                is_mnt_next = 1'b1;
                state_next  = S_REF;
            end
            L_ACT: begin
                instr_next  = encode(1'b0, 1'b1, 1'b1, low_idx, row_reg[low_idx]);
                is_mnt_next = 1'b1;
                pend_next   = pend_src & ~one_hot;
                state_next  = S_ACT;
            end
            L_DONE: begin
                done_next  = 1'b1;
                state_next = S_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            open_reg   <= '0;
            pend_reg   <= '0;
            instr_reg  <= '0;
            is_mnt_reg <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            bank_reg   <= '0;
            for (int i = 0; i < NUM_BANKS; i++) row_reg[i] <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            open_reg   <= open_next;
            pend_reg   <= pend_next;
            instr_reg  <= instr_next;
            is_mnt_reg <= is_mnt_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
            bank_reg   <= bank_next;
            if (state_reg == S_SCAN) row_reg[bank_reg] <= maint_bank_state[ROW_WIDTH-1:0];
        end
    end

    assign maint_busy = busy_reg;
    assign maint_done = done_reg;
    assign maint_bank = bank_reg;
    assign instr      = instr_reg;
    assign is_mnt     = is_mnt_reg;

endmodule

// File: tb/tb_refresh_restore_handler.sv
// Bench for refresh_restore_handler: table-driven sequences, random tracker contents and
// ready patterns, all compared against a command-list model built from the open-row table.
module tb_refresh_restore_handler;
    localparam int RW = 15, BW = 3, NB = 8;
    localparam int TRP = 6, TRFC = 44, TRRD = 4, TRCD = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          maint_req = 1'b0;
    logic          instr_ready = 1'b1;
    logic          maint_busy, maint_done, is_mnt;
    logic [BW-1:0] maint_bank;
    logic [RW:0]   maint_bank_state;
    logic [31:0]   instr;

    logic          trk_open [NB];
    logic [RW-1:0] trk_row  [NB];

    assign maint_bank_state = {trk_open[maint_bank], trk_row[maint_bank]};

    refresh_restore_handler #(
        .ROW_WIDTH(RW), .BANK_WIDTH(BW), .CS_WIDTH(1),
        .TRP(TRP), .TRFC(TRFC), .TRRD(TRRD), .TRCD(TRCD)
    ) dut (
        .clk(clk), .rst(rst), .maint_req(maint_req), .maint_busy(maint_busy),
        .maint_done(maint_done), .maint_bank(maint_bank), .maint_bank_state(maint_bank_state),
        .instr(instr), .is_mnt(is_mnt), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [31:0] mk(input logic ras, input logic cas, input logic we,
                                       input logic [BW-1:0] bank, input logic [RW-1:0] row);
        return {1'b1, ras, cas, we, 10'b0, bank, row};
    endfunction

    // ready pattern: 0 always ready, 1 toggling, 2 random
    int ready_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: instr_ready = 1'b1;
            1: instr_ready = ~instr_ready;
            default: instr_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Observer: timestamps command presentation/acceptance and busy/done edges
    int          cyc = 0;
    int          busy_rise, busy_fall, done_cnt, done_cyc, stall_err, present_cyc;
    bit          pending, prev_busy;
    logic [31:0] pinstr;
    logic [31:0] acc_instr [$];
    int          acc_present [$];
    int          acc_cyc [$];

    task automatic clear_mon();
        busy_rise = -1; busy_fall = -1; done_cnt = 0; done_cyc = -1;
        stall_err = 0; pending = 1'b0;
        acc_instr.delete(); acc_present.delete(); acc_cyc.delete();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (maint_busy && !prev_busy && busy_rise < 0) busy_rise = cyc;
        if (!maint_busy && prev_busy && busy_fall < 0) busy_fall = cyc;
        prev_busy = maint_busy;
        if (maint_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (is_mnt) begin
            if (!pending) begin
                pending = 1'b1;
                present_cyc = cyc;
                pinstr = instr;
            end else if (instr !== pinstr) stall_err++;
            if (instr_ready) begin
                acc_instr.push_back(instr);
                acc_present.push_back(present_cyc);
                acc_cyc.push_back(cyc);
                pending = 1'b0;
            end
        end else if (pending) stall_err++;
        if (rst) pending = 1'b0;
    end

    // Reference: command list and spacing derived directly from the open-row table
    logic [31:0] e_instr [$];
    int          e_gap [$];
    int          e_done_gap;

    task automatic build_expected();
        int n_open = 0;
        e_instr.delete(); e_gap.delete();
        for (int b = 0; b < NB; b++) if (trk_open[b]) begin
            e_instr.push_back(mk(1'b0, 1'b1, 1'b0, BW'(b), '0));
            e_gap.push_back(n_open == 0 ? NB : 1);
            n_open++;
        end
        e_instr.push_back(mk(1'b0, 1'b0, 1'b1, '0, '0));
        e_gap.push_back(n_open == 0 ? NB : TRP);
        for (int b = 0, k = 0; b < NB; b++) if (trk_open[b]) begin
            e_instr.push_back(mk(1'b0, 1'b1, 1'b1, BW'(b), trk_row[b]));
            e_gap.push_back(k == 0 ? TRFC : TRRD);
            k++;
        end
        e_done_gap = (n_open == 0) ? TRFC : TRCD;
    endtask

    task automatic run_seq(input string tag, input int mode, input bit hold,
                           input int exp_ncmd, input int exp_lat);
        int k;
        int n;
        build_expected();
        clear_mon();
        ready_mode = mode;
        @(posedge clk);
        #1 maint_req = 1'b1;
        k = 0;
        while (busy_rise < 0 && k < 50) begin @(posedge clk); k++; end
        #1;
        if (!hold) maint_req = 1'b0;
        k = 0;
        while (!(done_cnt > 0 && busy_fall >= 0) && k < 3000) begin @(posedge clk); k++; end
        chk($sformatf("%s finished", tag), (done_cnt > 0 && busy_fall >= 0), 1);
        chk($sformatf("%s ncmd", tag), acc_instr.size(), e_instr.size());
        if (exp_ncmd >= 0) chk($sformatf("%s ncmd_table", tag), acc_instr.size(), exp_ncmd);
        n = (acc_instr.size() < e_instr.size()) ? acc_instr.size() : e_instr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s instr[%0d]", tag, i), acc_instr[i], e_instr[i]);
            chk($sformatf("%s gap[%0d]", tag, i),
                acc_present[i] - (i == 0 ? busy_rise : acc_cyc[i-1]), e_gap[i]);
        end
        if (acc_cyc.size() > 0)
            chk($sformatf("%s done_gap", tag), done_cyc - acc_cyc[acc_cyc.size()-1], e_done_gap);
        chk($sformatf("%s done_pulses", tag), done_cnt, 1);
        chk($sformatf("%s busy_fall", tag), busy_fall, done_cyc + 1);
        chk($sformatf("%s stall_stable", tag), stall_err, 0);
        if (exp_lat >= 0) chk($sformatf("%s latency", tag), done_cyc - busy_rise, exp_lat);
        $display("seq %s: %0d commands accepted, done %0d cycles after busy", tag,
                 acc_instr.size(), done_cyc - busy_rise);
    endtask

    task automatic set_tracker(input logic [NB-1:0] mask, input int row_mode);
        for (int b = 0; b < NB; b++) begin
            trk_open[b] = mask[b];
            if (row_mode == 0) trk_row[b] = RW'(b * 'h100);
            else if (row_mode == 1) trk_row[b] = (b == 2) ? 15'h1234 : (b == 5) ? 15'h7FFF : RW'('h0A00 + b);
            else trk_row[b] = RW'($urandom_range(0, 32767));
        end
    endtask

    typedef struct {
        logic [NB-1:0] mask;
        int            row_mode;
        int            ready_mode;
        int            exp_ncmd;
        int            exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int k;
        vecs[0] = '{8'h00, 1, 0, 1, 52};
        vecs[1] = '{8'h24, 1, 0, 5, 69};
        vecs[2] = '{8'hFF, 0, 0, 17, 99};
        vecs[3] = '{8'h24, 1, 1, 5, -1};
        vecs[4] = '{8'h81, 0, 0, 5, 69};
        vecs[5] = '{8'h01, 0, 0, 3, 64};

        set_tracker(8'h00, 0);
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", maint_busy, 0);
        chk("reset done", maint_done, 0);
        chk("reset is_mnt", is_mnt, 0);
        chk("reset instr", instr, 0);
        chk("reset bank", maint_bank, 0);

        foreach (vecs[i]) begin
            set_tracker(vecs[i].mask, vecs[i].row_mode);
            run_seq($sformatf("vec%0d", i), vecs[i].ready_mode, 1'b0, vecs[i].exp_ncmd, vecs[i].exp_lat);
        end

        for (int r = 0; r < 6; r++) begin
            set_tracker(8'($urandom_range(0, 255)), 2);
            run_seq($sformatf("rand%0d", r), 2, 1'b0, -1, -1);
        end

        // Reset in the middle of the tRFC wait
        set_tracker(8'h24, 1);
        ready_mode = 0;
        clear_mon();
        @(posedge clk);
        #1 maint_req = 1'b1;
        k = 0;
        while (busy_rise < 0 && k < 50) begin @(posedge clk); k++; end
        #1 maint_req = 1'b0;
        k = 0;
        while (acc_instr.size() < 3 && k < 200) begin @(posedge clk); k++; end
        chk("rstmid ref_reached", acc_instr.size(), 3);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid is_mnt", is_mnt, 0);
        chk("rstmid busy", maint_busy, 0);
        chk("rstmid instr", instr, 0);
        clear_mon();
        repeat (60) @(posedge clk);
        chk("rstmid no_cmds", acc_instr.size(), 0);
        chk("rstmid no_done", done_cnt, 0);
        chk("rstmid no_busy", busy_rise, -1);
        run_seq("restart", 0, 1'b0, 5, 69);

        // Request held high across two sequences
        set_tracker(8'h24, 1);
        run_seq("held1", 0, 1'b1, 5, 69);
        run_seq("held2", 0, 1'b0, 5, 69);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
